// File: rtl/framebuffer_scanout.sv
// Framebuffer scan-out: VGA timing generator, scaled framebuffer address
// generation, 16-entry palette lookup and a two-stage output pipeline that
// keeps colour, syncs and frame_start aligned with the counter state that
// produced them.
module framebuffer_scanout #(
  parameter int H_VISIBLE             = 640,
  parameter int H_FRONT               = 16,
  parameter int H_SYNC                = 96,
  parameter int H_BACK                = 48,
  parameter int V_VISIBLE             = 480,
  parameter int V_FRONT               = 10,
  parameter int V_SYNC                = 2,
  parameter int V_BACK                = 33,
  parameter int FB_WIDTH              = 160,
  parameter int SCALE                 = 4,
  parameter int FRAMEBUFFER_ADDR_SIZE = 14
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic [FRAMEBUFFER_ADDR_SIZE:0] addr_vga,
  input  logic [3:0]                   data_vga,
  input  logic                         pal_wr_en,
  input  logic [3:0]                   pal_addr,
  input  logic [11:0]                  pal_data,
  output logic [3:0]                   vga_r,
  output logic [3:0]                   vga_g,
  output logic [3:0]                   vga_b,
  output logic                         hsync,
  output logic                         vsync,
  output logic                         frame_start
);

  localparam int AW      = FRAMEBUFFER_ADDR_SIZE + 1;
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Timing thresholds pre-sized to the 10-bit counters.
  localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  // The last visible line never advances row_base, which caps it at the
  // start of the final framebuffer row.
  localparam logic [9:0] V_LAST_VIS   = 10'(V_VISIBLE - 1);
  localparam logic [9:0] SCALE_DIV    = 10'(SCALE);
  localparam logic [9:0] SUB_LAST     = 10'(SCALE - 1);
  localparam logic [AW-1:0] ROW_STEP  = AW'(FB_WIDTH);

  // ---------------------------------------------------------------------
  // Reset synchroniser: assertion passes straight through, deassertion is
  // released after two clock edges.
  // ---------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  // Two-flop release synchroniser for the external asynchronous reset.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  // ---------------------------------------------------------------------
  // Stage 0: counters and row base
  // ---------------------------------------------------------------------
  logic [9:0]    h_count_q, h_count_d;
  logic [9:0]    v_count_q, v_count_d;
  logic [9:0]    v_sub_q, v_sub_d;       // line index within a scaled row
  logic [AW-1:0] row_base_q, row_base_d;
  logic          line_end, frame_end;

  // Next-state for the raster counters and the running framebuffer row base.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    line_end   = (h_count_q == H_LAST);
    frame_end  = line_end && (v_count_q == V_LAST);
    h_count_d  = line_end ? 10'd0 : h_count_q + 10'd1;
    v_count_d  = v_count_q;
    v_sub_d    = v_sub_q;
    row_base_d = row_base_q;
    if (frame_end) begin
      v_count_d  = 10'd0;
      v_sub_d    = 10'd0;
      row_base_d = '0;
    end else if (line_end) begin
      v_count_d = v_count_q + 10'd1;
      v_sub_d   = (v_sub_q == SUB_LAST) ? 10'd0 : v_sub_q + 10'd1;
      if ((v_sub_q == SUB_LAST) && (v_count_q < V_LAST_VIS))
        row_base_d = row_base_q + ROW_STEP;
    end
  end

  // Raster counter and row base registers.
  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      h_count_q  <= '0;
      v_count_q  <= '0;
      v_sub_q    <= '0;
      row_base_q <= '0;
    end else begin
      h_count_q  <= h_count_d;
      v_count_q  <= v_count_d;
      v_sub_q    <= v_sub_d;
      row_base_q <= row_base_d;
    end
  end

  logic visible_s0, hsync_raw, vsync_raw, first_px_s0;

  // Stage 0 decode; addr_vga is combinational so the framebuffer RAM
  // returns data_vga during stage 1.
  always_comb begin
    visible_s0  = (h_count_q < H_VIS) && (v_count_q < V_VIS);
    hsync_raw   = !((h_count_q >= H_SYNC_START) && (h_count_q < H_SYNC_END));
    vsync_raw   = !((v_count_q >= V_SYNC_START) && (v_count_q < V_SYNC_END));
    first_px_s0 = (h_count_q == 10'd0) && (v_count_q == 10'd0);
    addr_vga    = '0;
    if (visible_s0) addr_vga = row_base_q + AW'(h_count_q / SCALE_DIV);
  end

  // ---------------------------------------------------------------------
  // Stage 1: delay the control bits alongside the RAM read
  // ---------------------------------------------------------------------
  logic vis_s1_q, hsync_s1_q, vsync_s1_q, first_px_s1_q;

  // Stage 1 control register, idle (blanked, syncs inactive) in reset.
  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      vis_s1_q      <= 1'b0;
      hsync_s1_q    <= 1'b1;
      vsync_s1_q    <= 1'b1;
      first_px_s1_q <= 1'b0;
    end else begin
      vis_s1_q      <= visible_s0;
      hsync_s1_q    <= hsync_raw;
      vsync_s1_q    <= vsync_raw;
      first_px_s1_q <= first_px_s0;
    end
  end

  // ---------------------------------------------------------------------
  // Palette: 16 x 12-bit register file
  // ---------------------------------------------------------------------
  logic [11:0] palette_q [16];

  // Palette writes; reads elsewhere see the pre-edge contents, so a write
  // and a read of the same entry in one clock return the old colour.
  // NOTE: this small register file is reset on purpose so the greyscale
  // ramp is available without software setup; larger RAMs are not reset.
  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      for (int i = 0; i < 16; i++) palette_q[i] <= {4'(i), 4'(i), 4'(i)};
    end else if (pal_wr_en) begin
      palette_q[pal_addr] <= pal_data;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: registered outputs
  // ---------------------------------------------------------------------
  logic [11:0] colour_d, colour_q;
  logic        hsync_q, vsync_q, frame_start_q;

  // Colour lookup for the pixel whose index arrived this cycle.
  always_comb begin
    colour_d = 12'h000;
    if (vis_s1_q) colour_d = palette_q[data_vga];
  end

  // Output register stage.
  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      colour_q      <= 12'h000;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      colour_q      <= colour_d;
      hsync_q       <= hsync_s1_q;
      vsync_q       <= vsync_s1_q;
      frame_start_q <= first_px_s1_q;
    end
  end

  assign vga_r       = colour_q[11:8];
  assign vga_g       = colour_q[7:4];
  assign vga_b       = colour_q[3:0];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed testbench for framebuffer_scanout. A reduced-timing instance
// covers whole frames cheaply; a default-parameter instance covers the
// full-size addressing and horizontal timing over the first lines.
module tb_framebuffer_scanout;

  // Reduced timing: 48 clocks per line, 24 lines per frame.
  localparam int HV = 32, HF = 4, HS = 8, HB = 4, HT = HV + HF + HS + HB;
  localparam int VV = 16, VF = 2, VS = 2, VB = 4, VT = VV + VF + VS + VB;
  localparam int FBW = 8, SC = 4, FT = HT * VT;
  // Default timing.
  localparam int DHV = 640, DHF = 16, DHS = 96, DHT = 800;
  localparam int DVV = 480, DVF = 10, DVS = 2, DVT = 525;
  localparam int DFBW = 160, DSC = 4, DFT = DHT * DVT;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] addr_s, addr_d;
  logic [3:0]  data_s, data_d;
  logic        pal_wr_en = 1'b0;
  logic [3:0]  pal_addr = 4'd0;
  logic [11:0] pal_data = 12'h000;
  logic        pal_wr_en_d = 1'b0;
  logic [3:0]  pal_addr_d = 4'd0;
  logic [11:0] pal_data_d = 12'h000;
  logic [3:0]  r_s, g_s, b_s, r_d, g_d, b_d;
  logic        hsync_s, vsync_s, fs_s, hsync_d, vsync_d, fs_d;
  logic [11:0] rgb_s;

  int n_checks = 0;
  int n_fail   = 0;
  int pos      = 0;   // counter state index since the internal reset released
  bit in_rst   = 1'b0;
  logic [11:0] pal_m [16];

  assign rgb_s = {r_s, g_s, b_s};

  always #5 clock = ~clock;

  framebuffer_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .FB_WIDTH(FBW), .SCALE(SC), .FRAMEBUFFER_ADDR_SIZE(14)
  ) dut (
    .clock(clock), .reset(reset), .addr_vga(addr_s), .data_vga(data_s),
    .pal_wr_en(pal_wr_en), .pal_addr(pal_addr), .pal_data(pal_data),
    .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
    .hsync(hsync_s), .vsync(vsync_s), .frame_start(fs_s)
  );

  framebuffer_scanout dut_def (
    .clock(clock), .reset(reset), .addr_vga(addr_d), .data_vga(data_d),
    .pal_wr_en(pal_wr_en_d), .pal_addr(pal_addr_d), .pal_data(pal_data_d),
    .vga_r(r_d), .vga_g(g_d), .vga_b(b_d),
    .hsync(hsync_d), .vsync(vsync_d), .frame_start(fs_d)
  );

  // Framebuffer RAM models: one-clock read latency, data = addr[3:0].
  always @(posedge clock) begin
    data_s <= addr_s[3:0];
    data_d <= addr_d[3:0];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- expected-value functions ----------------
  function automatic int st_h(int s, int ht);
    return (s < 0) ? 0 : s % ht;
  endfunction

  function automatic int st_v(int s, int ht, int vt);
    return (s < 0) ? 0 : (s / ht) % vt;
  endfunction

  function automatic int exp_addr(int s, int hv, int vv, int ht, int vt, int fbw, int sc);
    int h, v;
    h = st_h(s, ht);
    v = st_v(s, ht, vt);
    if (h < hv && v < vv) return (v / sc) * fbw + h / sc;
    return 0;
  endfunction

  function automatic logic exp_hs(int s, int hv, int hf, int hsw, int ht);
    int h;
    h = st_h(s, ht);
    return (h >= hv + hf && h < hv + hf + hsw) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic exp_vs(int s, int vv, int vf, int vsw, int ht, int vt);
    int v;
    v = st_v(s, ht, vt);
    return (v >= vv + vf && v < vv + vf + vsw) ? 1'b0 : 1'b1;
  endfunction

  // Colour shown at position p of the reduced instance (state p-2).
  function automatic logic [11:0] exp_rgb(int p);
    int s, h, v;
    if (p < 2) return 12'h000;
    s = p - 2;
    h = st_h(s, HT);
    v = st_v(s, HT, VT);
    if (h < HV && v < VV) return pal_m[exp_addr(s, HV, VV, HT, VT, FBW, SC) % 16];
    return 12'h000;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
    if (!in_rst) pos++;
  endtask

  task automatic release_reset();
    reset  = 1'b1;
    in_rst = 1'b0;
    pos    = -2;   // two synchroniser edges before counting starts
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    reset  = 1'b0;
    in_rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (hsync_s !== 1'b1) begin n_fail++; $display("FAIL reset_hsync: got %b want 1", hsync_s); end
    n_checks++;
    if (vsync_s !== 1'b1) begin n_fail++; $display("FAIL reset_vsync: got %b want 1", vsync_s); end
    n_checks++;
    if (rgb_s !== 12'h000) begin n_fail++; $display("FAIL reset_colour: got %h want 000", rgb_s); end
    n_checks++;
    if (fs_s !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b want 0", fs_s); end
    n_checks++;
    if (addr_s !== 15'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", addr_s); end
    n_checks++;
    if (hsync_d !== 1'b1) begin n_fail++; $display("FAIL reset_hsync_def: got %b want 1", hsync_d); end
    n_checks++;
    if (fs_d !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start_def: got %b want 0", fs_d); end
  endtask

  // frame_start must rise exactly at position 2 (4th edge after release).
  task automatic test_release_latency(string tag);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (fs_s !== 1'(pos == 2)) begin
        n_fail++;
        $display("FAIL latency_%s pos %0d: frame_start got %b want %b", tag, pos, fs_s, pos == 2);
      end
      n_checks++;
      if (fs_d !== 1'(pos == 2)) begin
        n_fail++;
        $display("FAIL latency_def_%s pos %0d: frame_start got %b want %b", tag, pos, fs_d, pos == 2);
      end
    end
  endtask

  task automatic test_timing();
    int p, s, last_fs, run_hs, run_vs, run_hd;
    logic [14:0] ea;
    last_fs = 2;
    run_hs = 0; run_vs = 0; run_hd = 0;
    while (pos < 3300) begin
      tick();
      p = pos;
      s = p - 2;
      ea = 15'(exp_addr(p, HV, VV, HT, VT, FBW, SC));
      n_checks++;
      if (addr_s !== ea) begin n_fail++; $display("FAIL timing_addr pos %0d: got %0d want %0d", p, addr_s, ea); end
      n_checks++;
      if (hsync_s !== exp_hs(s, HV, HF, HS, HT)) begin
        n_fail++; $display("FAIL timing_hsync pos %0d: got %b", p, hsync_s);
      end
      n_checks++;
      if (vsync_s !== exp_vs(s, VV, VF, VS, HT, VT)) begin
        n_fail++; $display("FAIL timing_vsync pos %0d: got %b", p, vsync_s);
      end
      n_checks++;
      if (fs_s !== 1'(s % FT == 0)) begin
        n_fail++; $display("FAIL timing_frame_start pos %0d: got %b", p, fs_s);
      end
      n_checks++;
      if (rgb_s !== exp_rgb(p)) begin
        n_fail++; $display("FAIL timing_colour pos %0d: got %h want %h", p, rgb_s, exp_rgb(p));
      end
      ea = 15'(exp_addr(p, DHV, DVV, DHT, DVT, DFBW, DSC));
      n_checks++;
      if (addr_d !== ea) begin n_fail++; $display("FAIL def_addr pos %0d: got %0d want %0d", p, addr_d, ea); end
      n_checks++;
      if (hsync_d !== exp_hs(s, DHV, DHF, DHS, DHT)) begin
        n_fail++; $display("FAIL def_hsync pos %0d: got %b", p, hsync_d);
      end
      n_checks++;
      if (vsync_d !== exp_vs(s, DVV, DVF, DVS, DHT, DVT)) begin
        n_fail++; $display("FAIL def_vsync pos %0d: got %b", p, vsync_d);
      end
      n_checks++;
      if (fs_d !== 1'(s % DFT == 0)) begin
        n_fail++; $display("FAIL def_frame_start pos %0d: got %b", p, fs_d);
      end
      // Hand-picked points.
      if (p == 4) begin
        n_checks++;
        if (addr_s !== 15'd1) begin n_fail++; $display("FAIL addr_x4_y0: got %0d want 1", addr_s); end
      end
      if (p == 6) begin
        n_checks++;
        if (rgb_s !== 12'h111) begin n_fail++; $display("FAIL latency_x4_colour: got %h want 111", rgb_s); end
      end
      if (p == 34) begin
        n_checks++;
        if (rgb_s !== 12'h000) begin n_fail++; $display("FAIL blank_colour: got %h want 000", rgb_s); end
      end
      if (p == 751) begin
        n_checks++;
        if (addr_s !== 15'd31) begin n_fail++; $display("FAIL addr_last_pixel: got %0d want 31", addr_s); end
      end
      if (p == 2407) begin
        n_checks++;
        if (addr_d !== 15'd1) begin n_fail++; $display("FAIL def_addr_x7_y3: got %0d want 1", addr_d); end
      end
      if (p == 3040) begin
        n_checks++;
        if (addr_d !== 15'd0) begin n_fail++; $display("FAIL def_addr_blank: got %0d want 0", addr_d); end
      end
      if (p == 3200) begin
        n_checks++;
        if (addr_d !== 15'd160) begin n_fail++; $display("FAIL def_addr_x0_y4: got %0d want 160", addr_d); end
      end
      // Sync pulse widths.
      if (hsync_s === 1'b0) run_hs++;
      else if (run_hs != 0) begin
        n_checks++;
        if (run_hs != HS) begin n_fail++; $display("FAIL hsync_width: got %0d want %0d", run_hs, HS); end
        run_hs = 0;
      end
      if (vsync_s === 1'b0) run_vs++;
      else if (run_vs != 0) begin
        n_checks++;
        if (run_vs != VS * HT) begin n_fail++; $display("FAIL vsync_width: got %0d want %0d", run_vs, VS * HT); end
        run_vs = 0;
      end
      if (hsync_d === 1'b0) run_hd++;
      else if (run_hd != 0) begin
        n_checks++;
        if (run_hd != 96) begin n_fail++; $display("FAIL def_hsync_width: got %0d want 96", run_hd); end
        run_hd = 0;
      end
      if (fs_s === 1'b1) begin
        n_checks++;
        if (p - last_fs != FT) begin n_fail++; $display("FAIL frame_period: got %0d want %0d", p - last_fs, FT); end
        last_fs = p;
      end
    end
  endtask

  task automatic test_palette();
    for (int i = 0; i < FT && (pos % FT) != 22; i++) tick();
    n_checks++;
    if ((pos % FT) != 22) begin n_fail++; $display("FAIL palette_align: got %0d want 22", pos % FT); end
    // Write happens at the edge ending the cycle with state (22,0).
    pal_wr_en = 1'b1;
    pal_addr  = 4'd5;
    pal_data  = 12'hF0A;
    tick();
    pal_wr_en = 1'b0;
    n_checks++;   // state (21,0): looked up at the write edge -> old value
    if (rgb_s !== 12'h555) begin n_fail++; $display("FAIL palette_same_clock: got %h want 555", rgb_s); end
    tick();
    n_checks++;   // state (22,0)
    if (rgb_s !== 12'hF0A) begin n_fail++; $display("FAIL palette_next_clock: got %h want F0A", rgb_s); end
    tick();
    n_checks++;   // state (23,0)
    if (rgb_s !== 12'hF0A) begin n_fail++; $display("FAIL palette_hold: got %h want F0A", rgb_s); end
    tick();
    n_checks++;   // state (24,0): index 6 untouched
    if (rgb_s !== 12'h666) begin n_fail++; $display("FAIL palette_other_entry: got %h want 666", rgb_s); end
    pal_m[5] = 12'hF0A;
    for (int i = 0; i < FT; i++) begin
      tick();
      n_checks++;
      if (rgb_s !== exp_rgb(pos)) begin
        n_fail++; $display("FAIL palette_frame pos %0d: got %h want %h", pos, rgb_s, exp_rgb(pos));
      end
    end
  endtask

  task automatic test_mid_reset();
    // Advance to state (6,10): output shows (4,10) -> addr 17, index 1.
    for (int i = 0; i < FT && (pos % FT) != 486; i++) tick();
    n_checks++;
    if (addr_s !== 15'd17) begin n_fail++; $display("FAIL midreset_pre_addr: got %0d want 17", addr_s); end
    n_checks++;
    if (rgb_s !== 12'h111) begin n_fail++; $display("FAIL midreset_pre_colour: got %h want 111", rgb_s); end
    #2;
    reset  = 1'b0;
    in_rst = 1'b1;
    #1;   // no clock edge since assertion
    n_checks++;
    if (rgb_s !== 12'h000) begin n_fail++; $display("FAIL midreset_colour: got %h want 000", rgb_s); end
    n_checks++;
    if (hsync_s !== 1'b1) begin n_fail++; $display("FAIL midreset_hsync: got %b want 1", hsync_s); end
    n_checks++;
    if (vsync_s !== 1'b1) begin n_fail++; $display("FAIL midreset_vsync: got %b want 1", vsync_s); end
    n_checks++;
    if (fs_s !== 1'b0) begin n_fail++; $display("FAIL midreset_frame_start: got %b want 0", fs_s); end
    n_checks++;
    if (addr_s !== 15'd0) begin n_fail++; $display("FAIL midreset_addr: got %0d want 0", addr_s); end
    n_checks++;
    if (addr_d !== 15'd0) begin n_fail++; $display("FAIL midreset_addr_def: got %0d want 0", addr_d); end
    repeat (3) tick();
    release_reset();
    test_release_latency("after_midreset");
  endtask

  task automatic test_wrap();
    int p, s, fs_seen;
    logic [14:0] ea;
    fs_seen = 0;
    while (pos < FT + 5) begin
      tick();
      p = pos;
      s = p - 2;
      ea = 15'(exp_addr(p, HV, VV, HT, VT, FBW, SC));
      n_checks++;
      if (addr_s !== ea) begin n_fail++; $display("FAIL wrap_addr pos %0d: got %0d want %0d", p, addr_s, ea); end
      n_checks++;
      if (fs_s !== 1'(s % FT == 0)) begin n_fail++; $display("FAIL wrap_frame_start pos %0d: got %b", p, fs_s); end
      if (fs_s === 1'b1) fs_seen++;
      if (p == FT - 1) begin
        n_checks++;
        if (addr_s !== 15'd0) begin n_fail++; $display("FAIL wrap_last_blank: got %0d want 0", addr_s); end
      end
      if (p == FT) begin
        n_checks++;
        if (addr_s !== 15'd0) begin n_fail++; $display("FAIL wrap_origin_addr: got %0d want 0", addr_s); end
      end
      if (p == FT + 4) begin
        n_checks++;
        if (addr_s !== 15'd1) begin n_fail++; $display("FAIL wrap_row_base_cleared: got %0d want 1", addr_s); end
      end
    end
    n_checks++;
    if (fs_seen != 1) begin n_fail++; $display("FAIL wrap_single_frame_start: got %0d want 1", fs_seen); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) pal_m[i] = {4'(i), 4'(i), 4'(i)};
    test_reset();
    release_reset();
    test_release_latency("first");
    test_timing();
    test_palette();
    test_mid_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
